branch_redirect_ctrl: RTL and testbench
=======================================

// Module: branch_redirect_ctrl
// PURPOSE
// - Sequences the front end after a branch/jump resolves in EX: registers the taken target and drives a
//   valid/ready redirect to fetch. Tracks the MIPS delay slot (same issue pair or still queued) and
//   back-pressures EX while a redirect is outstanding.
// - Sits between the EX-stage branch judge and the fetch/issue front end of the dual-issue pipeline.
// PARAMETERS
// - PC_W   32  width of PC / target
// - CNT_W  32  width of perf counters (wrap-around)
// PORTS
// - clk              in   1      single clock, all state on posedge
// - rst              in   1      synchronous, active-high reset
// - ex_br_valid      in   1      branch/jump resolved in EX this cycle (already qualified by EX stall)
// - ex_br_taken      in   1      resolution result (branch_taken from judge)
// - ex_br_target     in   PC_W   resolved target (pc_branch_address)
// - ex_br_slot0      in   1      branch occupies issue slot 0
// - ex_slot1_valid   in   1      slot 1 holds a valid instruction this cycle
// - except_flush     in   1      exception/ERET flush from commit; highest priority
// - redirect_ready   in   1      fetch accepts redirect this cycle
// - ds_issued        in   1      issue unit has issued the held delay slot (pulse)
// - redirect_valid   out  1      redirect request to fetch
// - redirect_pc      out  PC_W   redirect target
// - flush_front      out  1      1-cycle pulse: drop fetch/issue queue entries younger than delay slot
// - ds_hold          out  1      issue unit must keep and issue exactly the queue head (delay slot)
// - ex_stall_req     out  1      EX must not present a new branch
// - cnt_branch       out  CNT_W  branches resolved
// - cnt_taken        out  CNT_W  branches taken
// BEHAVIOUR
// - Reset: state IDLE; redirect_valid=0, redirect_pc=0, flush_front=0, ds_hold=0, ex_stall_req=0, counters=0.
// - States: IDLE, REDIR_DS (redirect + delay slot pending), REDIR (redirect pending), DS (delay slot pending).
// - Delay-slot pending := ~(ex_br_slot0 & ex_slot1_valid) (branch in slot1, or slot0 with slot1 empty).
// - IDLE, ex_br_valid & ex_br_taken: capture target into redirect_pc; next state REDIR_DS if delay slot
//   pending else REDIR. Outputs registered: redirect_valid/ds_hold rise cycle N+1 (1-cycle latency).
// - IDLE, not taken: no state change; counters only.
// - REDIR_DS: redirect_valid=1, ds_hold=1. redirect_ready&ds_issued -> IDLE; redirect_ready only -> DS;
//   ds_issued only -> REDIR.
// - REDIR: redirect_valid=1; redirect_ready -> IDLE. DS: ds_hold=1; ds_issued -> IDLE.
// - redirect_pc stable while redirect_valid=1 until accepted (valid never drops without ready).
// - flush_front: registered pulse in the cycle after redirect_ready&redirect_valid.
// - ex_stall_req = (state != IDLE). ex_br_valid while not IDLE is a protocol error: ignored, not counted;
//   bench assertion flags it.
// - except_flush: next state IDLE, all outputs 0 next cycle, captured target dropped, no flush_front
//   pulse; a branch presented in the same cycle is ignored but still counted.
// - Counters: cnt_branch += ex_br_valid, cnt_taken += ex_br_valid&ex_br_taken (IDLE only); wrap at 2^CNT_W.
// - ds_issued outside REDIR_DS/DS and redirect_ready with redirect_valid=0 are ignored.
// STRUCTURE
// - cpu_ctrl_pkg: typedef enum logic[1:0] br_ctrl_state_t {IDLE,REDIR_DS,REDIR,DS}; redirect_t struct
//   {valid, pc}, shared with the fetch unit.
// - Sub-module: event_counter (CNT_W, inc, wrap), instantiated twice.
// - Single always_ff for state/outputs plus an always_comb next-state block; no latches.
// TESTING
// - Slot0 taken, slot1 valid, target 0xBFC0_0100, ready=1 at N+1 -> valid at N+1, flush_front at N+2, ds_hold never 1.
// - Slot1 taken, ready held 0 for 3 cycles, ds_issued at N+2 -> REDIR_DS->REDIR->IDLE; pc stable 0x8000_0040.
// - Not-taken BNE -> cnt_branch=1, cnt_taken=0, no redirect, ex_stall_req stays 0.
// - except_flush in REDIR_DS -> next cycle all outputs 0, IDLE, no flush_front.
// - ex_br_valid in REDIR -> ignored, counters unchanged, assertion fires.
// - rst mid-DS -> IDLE, counters 0; preload cnt_taken=0xFFFF_FFFF + taken -> wraps to 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared front-end control types: branch-redirect FSM states and the redirect
// request seen by the fetch unit.
package cpu_ctrl_pkg;

    localparam int unsigned PcW = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIR_DS = 2'd1,
        REDIR    = 2'd2,
        DS       = 2'd3
    } br_ctrl_state_t;

    typedef struct packed {
        logic           valid;
        logic [PcW-1:0] pc;
    } redirect_t;

    // A delay slot is still owed unless it issued alongside the branch in slot 1.
    function automatic logic ds_pending(input logic br_slot0, input logic slot1_valid);
        return ~(br_slot0 & slot1_valid);
    endfunction

endpackage

// File: rtl/event_counter.sv
// Free-running wrap-around event counter with synchronous active-high reset.
module event_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Redirects fetch after a taken EX-stage branch, tracks the pending delay slot
// and stalls EX until both the redirect and the delay slot are resolved.
module branch_redirect_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_br_valid,
    input  logic             ex_br_taken,
    input  logic [PC_W-1:0]  ex_br_target,
    input  logic             ex_br_slot0,
    input  logic             ex_slot1_valid,
    input  logic             except_flush,
    input  logic             redirect_ready,
    input  logic             ds_issued,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush_front,
    output logic             ds_hold,
    output logic             ex_stall_req,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken
);

    br_ctrl_state_t  state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            rv_q, ds_hold_q, flush_q, stall_q;
    logic            br_accept, taken_accept;

    // Branches arriving outside IDLE violate the stall protocol and are dropped.
    assign br_accept    = ex_br_valid & (state_q == IDLE);
    assign taken_accept = br_accept & ex_br_taken;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (except_flush) begin
            state_d = IDLE;
            pc_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (taken_accept) begin
                        pc_d    = ex_br_target;
                        state_d = ds_pending(ex_br_slot0, ex_slot1_valid) ? REDIR_DS : REDIR;
                    end
                end
                REDIR_DS: begin
                    if (redirect_ready && ds_issued) begin
                        state_d = IDLE;
                    end else if (redirect_ready) begin
                        state_d = DS;
                    end else if (ds_issued) begin
                        state_d = REDIR;
                    end
                end
                REDIR: begin
                    if (redirect_ready) begin
                        state_d = IDLE;
                    end
                end
                DS: begin
                    if (ds_issued) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            rv_q      <= 1'b0;
            ds_hold_q <= 1'b0;
            flush_q   <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rv_q      <= (state_d == REDIR_DS) || (state_d == REDIR);
            ds_hold_q <= (state_d == REDIR_DS) || (state_d == DS);
            stall_q   <= (state_d != IDLE);
            // An exception flush supersedes an accepted redirect: no front-end drop.
            flush_q   <= rv_q & redirect_ready & ~except_flush;
        end
    end

    assign redirect_valid = rv_q;
    assign redirect_pc    = pc_q;
    assign flush_front    = flush_q;
    assign ds_hold        = ds_hold_q;
    assign ex_stall_req   = stall_q;

    event_counter #(
        .W (CNT_W)
    ) u_cnt_branch (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (br_accept),
        .count_o (cnt_branch)
    );

    event_counter #(
        .W (CNT_W)
    ) u_cnt_taken (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (taken_accept),
        .count_o (cnt_taken)
    );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench: directed scenarios then random traffic against a flag-based
// reference model; a narrow-counter twin instance exercises counter wrap.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_br_valid, ex_br_taken, ex_br_slot0, ex_slot1_valid;
    logic [31:0] ex_br_target;
    logic        except_flush, redirect_ready, ds_issued;
    logic        redirect_valid, flush_front, ds_hold, ex_stall_req;
    logic [31:0] redirect_pc, cnt_branch, cnt_taken;
    logic        s_redirect_valid, s_flush_front, s_ds_hold, s_ex_stall_req;
    logic [31:0] s_redirect_pc;
    logic [3:0]  s_cnt_branch, s_cnt_taken;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.PC_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken),
        .ex_br_target(ex_br_target), .ex_br_slot0(ex_br_slot0), .ex_slot1_valid(ex_slot1_valid),
        .except_flush(except_flush), .redirect_ready(redirect_ready), .ds_issued(ds_issued),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_front(flush_front),
        .ds_hold(ds_hold), .ex_stall_req(ex_stall_req), .cnt_branch(cnt_branch),
        .cnt_taken(cnt_taken)
    );

    branch_redirect_ctrl #(.PC_W(32), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken),
        .ex_br_target(ex_br_target), .ex_br_slot0(ex_br_slot0), .ex_slot1_valid(ex_slot1_valid),
        .except_flush(except_flush), .redirect_ready(redirect_ready), .ds_issued(ds_issued),
        .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
        .flush_front(s_flush_front), .ds_hold(s_ds_hold), .ex_stall_req(s_ex_stall_req),
        .cnt_branch(s_cnt_branch), .cnt_taken(s_cnt_taken)
    );

    typedef struct {
        logic        rv;
        logic [31:0] pc;
        logic        pc_chk;
        logic        fl;
        logic        dsh;
        logic        st;
        logic [31:0] cb;
        logic [31:0] ct;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   prot_viol = 0;
    int   exp_viol = 0;
    bit   done = 1'b0;

    // Reference model: "redirect owed" and "delay slot owed" flags.
    bit          m_rp, m_dp, m_fl, m_pc_zero;
    logic [31:0] m_pc, m_cb, m_ct;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
        end
    endtask

    // Apply one cycle of inputs (called at negedge), advance the model, queue expectation.
    task automatic cyc(input bit r, input bit v, input bit tk, input logic [31:0] tgt,
                       input bit s0, input bit s1v, input bit exf, input bit rdy, input bit dsi);
        exp_t e;
        bit   idle;
        rst = r; ex_br_valid = v; ex_br_taken = tk; ex_br_target = tgt;
        ex_br_slot0 = s0; ex_slot1_valid = s1v; except_flush = exf;
        redirect_ready = rdy; ds_issued = dsi;
        if (r) begin
            m_rp = 0; m_dp = 0; m_fl = 0; m_pc = 0; m_pc_zero = 1; m_cb = 0; m_ct = 0;
        end else begin
            idle = !m_rp && !m_dp;
            m_fl = m_rp && rdy && !exf;
            if (idle && v) begin
                m_cb = m_cb + 1;
                if (tk) m_ct = m_ct + 1;
            end
            if (!idle && v) exp_viol++;
            if (exf) begin
                m_rp = 0; m_dp = 0; m_pc = 0; m_pc_zero = 1;
            end else if (idle) begin
                if (v && tk) begin
                    m_rp = 1; m_dp = !(s0 && s1v); m_pc = tgt; m_pc_zero = 0;
                end
            end else begin
                if (m_rp && rdy) m_rp = 0;
                if (m_dp && dsi) m_dp = 0;
            end
        end
        e.rv = m_rp; e.pc = m_pc; e.pc_chk = m_rp || m_pc_zero; e.fl = m_fl;
        e.dsh = m_dp; e.st = m_rp || m_dp; e.cb = m_cb; e.ct = m_ct;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_cyc(input bit rdy, input bit dsi);
        cyc(0, 0, 0, 32'h0, 0, 0, 0, rdy, dsi);
    endtask

    // Protocol monitor: a branch presented while EX is stalled.
    always @(posedge clk) begin
        if (!rst && ex_br_valid && ex_stall_req) begin
            prot_viol++;
            $display("protocol: ex_br_valid while ex_stall_req @%0t", $time);
        end
    end

    // Output monitor: pops one expectation per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("redirect_valid", {31'b0, redirect_valid}, {31'b0, e.rv});
                if (e.pc_chk) check("redirect_pc", redirect_pc, e.pc);
                check("flush_front", {31'b0, flush_front}, {31'b0, e.fl});
                check("ds_hold", {31'b0, ds_hold}, {31'b0, e.dsh});
                check("ex_stall_req", {31'b0, ex_stall_req}, {31'b0, e.st});
                check("cnt_branch", cnt_branch, e.cb);
                check("cnt_taken", cnt_taken, e.ct);
                check("cnt_branch_w4", {28'b0, s_cnt_branch}, {28'b0, e.cb[3:0]});
                check("cnt_taken_w4", {28'b0, s_cnt_taken}, {28'b0, e.ct[3:0]});
            end
        end
    end

    initial begin
        bit r, v, tk, s0, s1v, exf, rdy, dsi;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
        idle_cyc(0, 0);

        // Slot0 taken with slot1 valid: no delay slot, accepted at N+1.
        cyc(0, 1, 1, 32'hBFC0_0100, 1, 1, 0, 0, 0);
        idle_cyc(1, 0);
        idle_cyc(0, 0);
        idle_cyc(0, 0);

        // Slot1 taken: ready low 3 cycles, delay slot issued at N+2.
        cyc(0, 1, 1, 32'h8000_0040, 0, 1, 0, 0, 0);
        idle_cyc(0, 0);
        idle_cyc(0, 1);
        idle_cyc(0, 0);
        idle_cyc(1, 0);
        idle_cyc(0, 0);

        // Not-taken branch: counters only.
        cyc(0, 1, 0, 32'h1234_5678, 1, 0, 0, 0, 0);
        idle_cyc(0, 0);

        // Exception flush while redirect and delay slot both pending.
        cyc(0, 1, 1, 32'h0000_0200, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
        idle_cyc(0, 0);

        // Exception flush in IDLE alongside a taken branch: counted, not taken up.
        cyc(0, 1, 1, 32'h0000_0300, 1, 1, 1, 0, 0);
        idle_cyc(0, 0);

        // Branch presented during REDIR is ignored.
        cyc(0, 1, 1, 32'h0000_0400, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 32'h0000_0500, 1, 0, 0, 0, 0);
        idle_cyc(1, 0);
        idle_cyc(0, 0);

        // Reset in the middle of DS.
        cyc(0, 1, 1, 32'h0000_0600, 0, 1, 0, 0, 0);
        idle_cyc(1, 0);
        idle_cyc(0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_cyc(0, 0);

        // Sixteen taken branches wrap the 4-bit twin counters back to zero.
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 1, 32'h0000_1000 + 32'(i * 4), 1, 1, 0, 0, 0);
            idle_cyc(1, 0);
        end
        idle_cyc(0, 0);

        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            v   = !m_rp && !m_dp && ($urandom_range(0, 1) == 1);
            tk  = ($urandom_range(0, 2) != 0);
            s0  = $urandom_range(0, 1) == 1;
            s1v = $urandom_range(0, 1) == 1;
            exf = ($urandom_range(0, 24) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            dsi = ($urandom_range(0, 2) == 0);
            cyc(r, v, tk, $urandom & 32'hFFFF_FFFC, s0, s1v, exf, rdy, dsi);
        end
        idle_cyc(0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("protocol_violations", 32'(prot_viol), 32'(exp_viol));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        done = 1'b1;
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: bench did not complete, got running expected finished");
            $fatal(1, "timeout");
        end
    end

endmodule
